// File: rtl/rob_pkg.sv
// ----------------------------------------------------------------------------
// rob_pkg
// Shared types and sizing for the reorder buffer.
//   - ROB_ENTRY     : one reorder-buffer slot
//   - RETIRE_PACKET : {complete, ar_idx, t_idx}, the record the architectural
//                     map table consumes at retirement
//   - way_popcount  : number of set bits in a per-way vector
// N_ROB_ENTRIES must be a power of two. Head/tail arithmetic relies on the
// natural wrap of an ROB_IDX_BITS-wide index.
// ----------------------------------------------------------------------------
`ifndef SUPERSCALAR_WAYS
`define SUPERSCALAR_WAYS 2
`endif
`ifndef N_ARCH_REG_BITS
`define N_ARCH_REG_BITS 5
`endif
`ifndef N_PHYS_REG_BITS
`define N_PHYS_REG_BITS 6
`endif
`ifndef N_ROB_ENTRIES
`define N_ROB_ENTRIES 32
`endif
`ifndef ROB_IDX_BITS
`define ROB_IDX_BITS $clog2(`N_ROB_ENTRIES)
`endif

package rob_pkg;

    localparam int WAYS            = `SUPERSCALAR_WAYS;
    localparam int N_ROB_ENTRIES   = `N_ROB_ENTRIES;
    localparam int ROB_IDX_BITS    = `ROB_IDX_BITS;
    localparam int N_ARCH_REG_BITS = `N_ARCH_REG_BITS;
    localparam int N_PHYS_REG_BITS = `N_PHYS_REG_BITS;

    typedef logic [ROB_IDX_BITS-1:0]    rob_idx_t;
    typedef logic [ROB_IDX_BITS:0]      rob_cnt_t;
    typedef logic [N_ARCH_REG_BITS-1:0] arch_t;
    typedef logic [N_PHYS_REG_BITS-1:0] phys_t;

    typedef struct packed {
        logic  valid;
        logic  done;
        logic  mispredict;
        logic  has_dest;
        arch_t ar_idx;
        phys_t t_idx;
        phys_t told_idx;
    } ROB_ENTRY;

    typedef struct packed {
        logic  complete;
        arch_t ar_idx;
        phys_t t_idx;
    } RETIRE_PACKET;

    // Count of set bits in a per-way request/grant vector.
    function automatic rob_cnt_t way_popcount(input logic [WAYS-1:0] v);
        rob_cnt_t n;
        n = '0;
        for (int i = 0; i < WAYS; i++) begin
            n = n + rob_cnt_t'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/rob_if.sv
// ----------------------------------------------------------------------------
// rob_if
// Dispatch, completion (CDB) and retirement signals of the reorder buffer.
//   master : the pipeline side (drives dispatch/CDB, observes retirement)
//   slave  : the reorder buffer itself
// Dispatch : dispatch_valid/ar_idx/t_idx/told_idx/has_dest in,
//            dispatch_rob_idx and rob_free_slots out
// CDB      : cdb_valid/cdb_rob_idx/cdb_mispredict in
// Retire   : retire_out/retire_valid/retire_told_idx out, squash, rob_empty
// ----------------------------------------------------------------------------
interface rob_if;
    import rob_pkg::*;

    logic         [WAYS-1:0] dispatch_valid;
    arch_t        [WAYS-1:0] dispatch_ar_idx;
    phys_t        [WAYS-1:0] dispatch_t_idx;
    phys_t        [WAYS-1:0] dispatch_told_idx;
    logic         [WAYS-1:0] dispatch_has_dest;
    rob_idx_t     [WAYS-1:0] dispatch_rob_idx;
    rob_cnt_t                rob_free_slots;

    logic         [WAYS-1:0] cdb_valid;
    rob_idx_t     [WAYS-1:0] cdb_rob_idx;
    logic         [WAYS-1:0] cdb_mispredict;

    RETIRE_PACKET [WAYS-1:0] retire_out;
    logic         [WAYS-1:0] retire_valid;
    phys_t        [WAYS-1:0] retire_told_idx;
    logic                    squash;
    logic                    rob_empty;

    modport master (
        output dispatch_valid, dispatch_ar_idx, dispatch_t_idx,
               dispatch_told_idx, dispatch_has_dest,
               cdb_valid, cdb_rob_idx, cdb_mispredict,
        input  dispatch_rob_idx, rob_free_slots,
               retire_out, retire_valid, retire_told_idx, squash, rob_empty
    );

    modport slave (
        input  dispatch_valid, dispatch_ar_idx, dispatch_t_idx,
               dispatch_told_idx, dispatch_has_dest,
               cdb_valid, cdb_rob_idx, cdb_mispredict,
        output dispatch_rob_idx, rob_free_slots,
               retire_out, retire_valid, retire_told_idx, squash, rob_empty
    );
endinterface

// File: rtl/rob_retire_select.sv
// ----------------------------------------------------------------------------
// rob_retire_select
// Combinational in-order retire picker over the WAYS oldest entries
// (index 0 = head).
//   head_valid/head_done/head_mispredict : flags of head+i
//   retire_valid : way i retires when head..head+i are all valid and done
//                  and none of head..head+i-1 is a mispredicted branch
//   squash       : a retiring way is a mispredicted branch
// ----------------------------------------------------------------------------
module rob_retire_select
    import rob_pkg::*;
(
    input  logic [WAYS-1:0] head_valid,
    input  logic [WAYS-1:0] head_done,
    input  logic [WAYS-1:0] head_mispredict,
    output logic [WAYS-1:0] retire_valid,
    output logic            squash
);

    logic chain_s;

    // Walk from the head; a not-ready entry or a retiring mispredict stops younger ways.
    always_comb begin
        retire_valid = '0;
        chain_s      = 1'b1;
        for (int i = 0; i < WAYS; i++) begin
            retire_valid[i] = chain_s & head_valid[i] & head_done[i];
            chain_s         = retire_valid[i] & ~head_mispredict[i];
        end
        squash = |(retire_valid & head_mispredict);
    end

endmodule

// File: rtl/rob.sv
// ----------------------------------------------------------------------------
// rob
// Circular reorder buffer: allocates WAYS entries per cycle at the tail,
// marks entries done from CDB broadcasts, retires up to WAYS entries in
// order from the head, and flushes itself when a mispredicted branch retires.
//   clock, reset : system clock, asynchronous active-high reset
//   bus          : rob_if.slave (dispatch, CDB, retire, status)
// dispatch_rob_idx, retire_* and squash are combinational from registered
// state; rob_free_slots is a register. count alone separates full from empty.
// ----------------------------------------------------------------------------
module rob
    import rob_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    rob_if.slave  bus
);

    ROB_ENTRY entries_q [N_ROB_ENTRIES];
    ROB_ENTRY entries_d [N_ROB_ENTRIES];
    rob_idx_t head_q, head_d;
    rob_idx_t tail_q, tail_d;
    rob_cnt_t count_q, count_d;
    rob_cnt_t free_slots_q, free_slots_d;

    rob_idx_t     [WAYS-1:0] head_idx_s;
    logic         [WAYS-1:0] head_valid_s;
    logic         [WAYS-1:0] head_done_s;
    logic         [WAYS-1:0] head_mispredict_s;
    logic         [WAYS-1:0] retire_valid_s;
    logic                    squash_s;
    RETIRE_PACKET [WAYS-1:0] retire_out_s;
    phys_t        [WAYS-1:0] retire_told_s;
    rob_idx_t     [WAYS-1:0] dispatch_idx_s;
    rob_cnt_t                n_disp_s;
    rob_cnt_t                n_acc_s;
    rob_cnt_t                n_ret_s;
    logic                    disp_ok_s;
    logic         [WAYS-1:0] cdb_hit_s;

    // Gather the flags of the WAYS oldest entries and the slots the dispatch ways would take.
    always_comb begin
        for (int i = 0; i < WAYS; i++) begin
            head_idx_s[i]        = head_q + rob_idx_t'(i);
            head_valid_s[i]      = entries_q[head_idx_s[i]].valid;
            head_done_s[i]       = entries_q[head_idx_s[i]].done;
            head_mispredict_s[i] = entries_q[head_idx_s[i]].mispredict;
            dispatch_idx_s[i]    = tail_q + rob_idx_t'(i);
        end
    end

    rob_retire_select u_retire_select (
        .head_valid      (head_valid_s),
        .head_done       (head_done_s),
        .head_mispredict (head_mispredict_s),
        .retire_valid    (retire_valid_s),
        .squash          (squash_s)
    );

    // Build retire packets; ways that do not retire present all-zero fields.
    always_comb begin
        for (int i = 0; i < WAYS; i++) begin
            if (retire_valid_s[i]) begin
                retire_out_s[i].complete = entries_q[head_idx_s[i]].has_dest;
                retire_out_s[i].ar_idx   = entries_q[head_idx_s[i]].ar_idx;
                retire_out_s[i].t_idx    = entries_q[head_idx_s[i]].t_idx;
                // Told only means something to the free list when a register was written.
                retire_told_s[i]         = entries_q[head_idx_s[i]].has_dest ?
                                           entries_q[head_idx_s[i]].told_idx : '0;
            end else begin
                retire_out_s[i]  = '0;
                retire_told_s[i] = '0;
            end
        end
    end

    // Next-state: completion, retirement, allocation, or a full flush on squash.
    always_comb begin
        entries_d    = entries_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        free_slots_d = free_slots_q;
        cdb_hit_s    = '0;
        n_disp_s     = way_popcount(bus.dispatch_valid);
        n_ret_s      = way_popcount(retire_valid_s);
        // Uses last cycle's free count: slots released by this cycle's retirement are not reusable yet.
        disp_ok_s    = (n_disp_s <= free_slots_q) && !squash_s;
        n_acc_s      = disp_ok_s ? n_disp_s : '0;

        if (squash_s) begin
            for (int k = 0; k < N_ROB_ENTRIES; k++) begin
                entries_d[k] = '0;
            end
            head_d       = '0;
            tail_d       = '0;
            count_d      = '0;
            free_slots_d = rob_cnt_t'(N_ROB_ENTRIES);
        end else begin
            for (int i = 0; i < WAYS; i++) begin
                cdb_hit_s[i] = bus.cdb_valid[i] && entries_q[bus.cdb_rob_idx[i]].valid;
                entries_d[bus.cdb_rob_idx[i]].done =
                    entries_d[bus.cdb_rob_idx[i]].done | cdb_hit_s[i];
                entries_d[bus.cdb_rob_idx[i]].mispredict =
                    entries_d[bus.cdb_rob_idx[i]].mispredict | (cdb_hit_s[i] & bus.cdb_mispredict[i]);
            end
            for (int i = 0; i < WAYS; i++) begin
                entries_d[head_idx_s[i]].valid =
                    entries_d[head_idx_s[i]].valid & ~retire_valid_s[i];
            end
            // Accepted dispatch only lands in free slots, so it never overlaps a retiring entry.
            for (int i = 0; i < WAYS; i++) begin
                entries_d[dispatch_idx_s[i]] = (disp_ok_s && bus.dispatch_valid[i]) ?
                    '{valid:      1'b1,
                      done:       1'b0,
                      mispredict: 1'b0,
                      has_dest:   bus.dispatch_has_dest[i],
                      ar_idx:     bus.dispatch_ar_idx[i],
                      t_idx:      bus.dispatch_t_idx[i],
                      told_idx:   bus.dispatch_told_idx[i]} :
                    entries_d[dispatch_idx_s[i]];
            end
            head_d       = head_q + rob_idx_t'(n_ret_s);
            tail_d       = tail_q + rob_idx_t'(n_acc_s);
            count_d      = count_q + n_acc_s - n_ret_s;
            free_slots_d = rob_cnt_t'(N_ROB_ENTRIES) - count_d;
        end
    end

    // State registers with asynchronous reset to an empty buffer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_ROB_ENTRIES; k++) begin
                entries_q[k] <= '0;
            end
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            free_slots_q <= rob_cnt_t'(N_ROB_ENTRIES);
        end else begin
            for (int k = 0; k < N_ROB_ENTRIES; k++) begin
                entries_q[k] <= entries_d[k];
            end
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            free_slots_q <= free_slots_d;
        end
    end

    assign bus.dispatch_rob_idx = dispatch_idx_s;
    assign bus.rob_free_slots   = free_slots_q;
    assign bus.retire_out       = retire_out_s;
    assign bus.retire_valid     = retire_valid_s;
    assign bus.retire_told_idx  = retire_told_s;
    assign bus.squash           = squash_s;
    assign bus.rob_empty        = (count_q == '0);

endmodule

// File: tb/tb_rob.sv
// ----------------------------------------------------------------------------
// tb_rob
// Directed bench for the reorder buffer. Every accepted dispatch is pushed to
// a scoreboard queue together with the done/mispredict state the bench itself
// applies over the CDB; each cycle the expected retirement is derived from
// the queue head and compared with the DUT, then the queue is popped.
// ----------------------------------------------------------------------------
module tb_rob;
    import rob_pkg::*;

    typedef struct {
        rob_idx_t idx;
        arch_t    ar;
        phys_t    t;
        phys_t    told;
        logic     hd;
        logic     done;
        logic     mp;
    } sb_t;

    logic clock;
    logic reset;
    rob_if bus ();

    rob dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    sb_t      sb_q [$];
    int       model_count;
    rob_idx_t model_tail;
    int       n_cmp;
    int       n_fail;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic RETIRE_PACKET mk_pkt(input logic c, input arch_t a, input phys_t t);
        RETIRE_PACKET p;
        p.complete = c;
        p.ar_idx   = a;
        p.t_idx    = t;
        return p;
    endfunction

    task automatic clear_inputs();
        bus.dispatch_valid    = '0;
        bus.dispatch_ar_idx   = '0;
        bus.dispatch_t_idx    = '0;
        bus.dispatch_told_idx = '0;
        bus.dispatch_has_dest = '0;
        bus.cdb_valid         = '0;
        bus.cdb_rob_idx       = '0;
        bus.cdb_mispredict    = '0;
    endtask

    task automatic drive_disp(input int w, input arch_t ar, input phys_t t, input phys_t told, input logic hd);
        bus.dispatch_valid[w]    = 1'b1;
        bus.dispatch_ar_idx[w]   = ar;
        bus.dispatch_t_idx[w]    = t;
        bus.dispatch_told_idx[w] = told;
        bus.dispatch_has_dest[w] = hd;
    endtask

    task automatic drive_cdb(input int w, input rob_idx_t idx, input logic mp);
        bus.cdb_valid[w]      = 1'b1;
        bus.cdb_rob_idx[w]    = idx;
        bus.cdb_mispredict[w] = mp;
    endtask

    // Compare this cycle's outputs with the model, advance the model, clock once.
    task automatic step();
        int              exp_n;
        logic            exp_sq;
        logic [WAYS-1:0] exp_rv;
        int              n_disp;
        int              free_before;
        sb_t             e;
        exp_n  = 0;
        exp_sq = 1'b0;
        exp_rv = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (w == exp_n && w < sb_q.size() && !exp_sq && sb_q[w].done) begin
                exp_rv[w] = 1'b1;
                exp_n++;
                if (sb_q[w].mp) exp_sq = 1'b1;
            end
        end
        check("retire_valid", bus.retire_valid, exp_rv);
        check("squash", bus.squash, exp_sq);
        check("free_slots", bus.rob_free_slots, N_ROB_ENTRIES - model_count);
        check("rob_empty", bus.rob_empty, model_count == 0);
        for (int w = 0; w < WAYS; w++) begin
            check($sformatf("dispatch_rob_idx[%0d]", w), bus.dispatch_rob_idx[w], model_tail + rob_idx_t'(w));
        end
        for (int w = 0; w < exp_n; w++) begin
            check($sformatf("retire_out[%0d]", w), bus.retire_out[w],
                  mk_pkt(sb_q[w].hd, sb_q[w].ar, sb_q[w].t));
            check($sformatf("retire_told[%0d]", w), bus.retire_told_idx[w],
                  sb_q[w].hd ? sb_q[w].told : phys_t'(0));
        end

        free_before = N_ROB_ENTRIES - model_count;
        for (int w = 0; w < exp_n; w++) void'(sb_q.pop_front());
        if (exp_sq) begin
            sb_q.delete();
            model_count = 0;
            model_tail  = '0;
        end else begin
            for (int w = 0; w < WAYS; w++) begin
                if (bus.cdb_valid[w]) begin
                    foreach (sb_q[k]) begin
                        if (sb_q[k].idx == bus.cdb_rob_idx[w]) begin
                            sb_q[k].done = 1'b1;
                            sb_q[k].mp   = sb_q[k].mp | bus.cdb_mispredict[w];
                        end
                    end
                end
            end
            model_count = model_count - exp_n;
            n_disp = $countones(bus.dispatch_valid);
            if (n_disp <= free_before) begin
                for (int w = 0; w < n_disp; w++) begin
                    e.idx  = model_tail + rob_idx_t'(w);
                    e.ar   = bus.dispatch_ar_idx[w];
                    e.t    = bus.dispatch_t_idx[w];
                    e.told = bus.dispatch_told_idx[w];
                    e.hd   = bus.dispatch_has_dest[w];
                    e.done = 1'b0;
                    e.mp   = 1'b0;
                    sb_q.push_back(e);
                end
                model_tail  = model_tail + rob_idx_t'(n_disp);
                model_count = model_count + n_disp;
            end else begin
                $display("note: protocol violation, %0d-way dispatch with %0d free slots refused",
                         n_disp, free_before);
            end
        end
        @(posedge clock);
        #1;
        clear_inputs();
    endtask

    // Asynchronous reset: outputs must clear before any clock edge arrives.
    task automatic do_reset();
        reset = 1'b1;
        #3;
        check("rst_retire_valid", bus.retire_valid, '0);
        check("rst_retire_out", bus.retire_out, '0);
        check("rst_retire_told", bus.retire_told_idx, '0);
        check("rst_squash", bus.squash, 1'b0);
        check("rst_empty", bus.rob_empty, 1'b1);
        check("rst_free", bus.rob_free_slots, N_ROB_ENTRIES);
        @(posedge clock);
        #1;
        reset = 1'b0;
        sb_q.delete();
        model_count = 0;
        model_tail  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int       issued;
        int       prev_n;
        int       cur_n;
        rob_idx_t prev_idx [WAYS];
        rob_idx_t cur_idx  [WAYS];

        n_cmp       = 0;
        n_fail      = 0;
        model_count = 0;
        model_tail  = '0;
        clear_inputs();

        // Reset and idle
        do_reset();
        step();

        // Basic two-way dispatch, complete, retire
        drive_disp(0, 5'd3, 6'd40, 6'd10, 1'b1);
        drive_disp(1, 5'd5, 6'd41, 6'd11, 1'b1);
        step();
        drive_cdb(0, 5'd0, 1'b0);
        drive_cdb(1, 5'd1, 1'b0);
        step();
        check("basic_rv", bus.retire_valid, 2'b11);
        check("basic_out0", bus.retire_out[0], mk_pkt(1'b1, 5'd3, 6'd40));
        check("basic_out1", bus.retire_out[1], mk_pkt(1'b1, 5'd5, 6'd41));
        step();
        check("basic_free", bus.rob_free_slots, 6'd32);
        step();

        // Fill to full, reject while full, retire one, still reject 2-way at free = 1
        do_reset();
        for (int c = 0; c < 16; c++) begin
            drive_disp(0, arch_t'(c), phys_t'(2 * c), phys_t'(c), 1'b1);
            drive_disp(1, arch_t'(c + 16), phys_t'(2 * c + 1), phys_t'(c + 32), 1'b1);
            step();
        end
        check("full_free", bus.rob_free_slots, 6'd0);
        drive_disp(0, 5'd1, 6'd60, 6'd61, 1'b1);
        drive_disp(1, 5'd2, 6'd62, 6'd63, 1'b1);
        step();
        check("full_tail_kept", bus.dispatch_rob_idx[0], 5'd0);
        drive_cdb(0, 5'd0, 1'b0);
        step();
        check("full_one_retire", bus.retire_valid, 2'b01);
        drive_disp(0, 5'd1, 6'd60, 6'd61, 1'b1);
        drive_disp(1, 5'd2, 6'd62, 6'd63, 1'b1);
        step();
        check("free_one", bus.rob_free_slots, 6'd1);
        drive_disp(0, 5'd1, 6'd60, 6'd61, 1'b1);
        drive_disp(1, 5'd2, 6'd62, 6'd63, 1'b1);
        step();
        check("free_one_kept", bus.rob_free_slots, 6'd1);

        // Younger done before older: nothing retires until the head completes
        do_reset();
        drive_disp(0, 5'd8, 6'd20, 6'd2, 1'b1);
        drive_disp(1, 5'd9, 6'd21, 6'd3, 1'b1);
        step();
        drive_cdb(0, 5'd1, 1'b0);
        step();
        check("ooo_no_retire", bus.retire_valid, 2'b00);
        drive_cdb(0, 5'd0, 1'b0);
        step();
        check("ooo_both", bus.retire_valid, 2'b11);
        step();

        // Mispredicted branch at head: only it retires, squash, then empty
        do_reset();
        drive_disp(0, 5'd4, 6'd30, 6'd5, 1'b1);
        drive_disp(1, 5'd6, 6'd31, 6'd7, 1'b1);
        step();
        drive_cdb(0, 5'd0, 1'b1);
        drive_cdb(1, 5'd1, 1'b0);
        step();
        check("mp_rv", bus.retire_valid, 2'b01);
        check("mp_squash", bus.squash, 1'b1);
        drive_disp(0, 5'd12, 6'd50, 6'd51, 1'b1);
        drive_cdb(1, 5'd1, 1'b0);
        step();
        check("mp_empty", bus.rob_empty, 1'b1);
        check("mp_tail0", bus.dispatch_rob_idx[0], 5'd0);
        drive_disp(0, 5'd13, 6'd52, 6'd53, 1'b1);
        step();
        drive_cdb(0, 5'd0, 1'b0);
        step();
        check("mp_head0_retire", bus.retire_valid, 2'b01);
        step();

        // No destination register: retires but does not update the map
        do_reset();
        drive_disp(0, 5'd7, 6'd50, 6'd20, 1'b0);
        step();
        drive_cdb(0, 5'd0, 1'b0);
        step();
        check("nodest_rv", bus.retire_valid, 2'b01);
        check("nodest_out", bus.retire_out[0], mk_pkt(1'b0, 5'd7, 6'd50));
        check("nodest_told", bus.retire_told_idx[0], 6'd0);
        step();

        // 100 instructions streaming across the pointer wrap
        do_reset();
        issued = 0;
        prev_n = 0;
        for (int c = 0; c < 56; c++) begin
            cur_n = 0;
            for (int w = 0; w < WAYS; w++) begin
                if (issued < 100) begin
                    drive_disp(w, arch_t'($urandom_range(31, 0)), phys_t'($urandom_range(63, 0)),
                               phys_t'($urandom_range(63, 0)), 1'($urandom_range(1, 0)));
                    cur_idx[w] = model_tail + rob_idx_t'(w);
                    cur_n++;
                    issued++;
                end
            end
            for (int w = 0; w < prev_n; w++) drive_cdb(w, prev_idx[w], 1'b0);
            check("wrap_count_bound", bus.rob_free_slots <= 6'd32, 1'b1);
            step();
            prev_n = cur_n;
            for (int w = 0; w < WAYS; w++) prev_idx[w] = cur_idx[w];
        end
        check("wrap_drained", bus.rob_empty, 1'b1);

        // Reset mid-stream with 10 live entries
        for (int c = 0; c < 5; c++) begin
            drive_disp(0, arch_t'(c), phys_t'(c + 10), phys_t'(c), 1'b1);
            drive_disp(1, arch_t'(c + 8), phys_t'(c + 20), phys_t'(c + 1), 1'b1);
            step();
        end
        drive_cdb(0, model_tail - 5'd10, 1'b0);
        drive_cdb(1, model_tail - 5'd9, 1'b0);
        step();
        check("pre_reset_rv", bus.retire_valid, 2'b11);
        check("pre_reset_free", bus.rob_free_slots, 6'd22);
        do_reset();
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
